// File: rtl/uart_tfifo_pkg.sv
// Shared constants and types for the UART transmit FIFO.
// FIFO_WIDTH / FIFO_DEPTH / POINTER_W / COUNTER_W size the storage, the
// pointers and the occupancy counter. UART_TFIFO_AE_LEVEL is the default
// almost-empty threshold.
package uart_tfifo_pkg;

    localparam int FIFO_WIDTH          = 8;
    localparam int FIFO_DEPTH          = 16;
    localparam int POINTER_W           = 4;
    localparam int COUNTER_W           = 5;
    localparam int UART_TFIFO_AE_LEVEL = 2;

    typedef logic [FIFO_WIDTH-1:0] fifo_data_t;
    typedef logic [POINTER_W-1:0]  fifo_ptr_t;
    typedef logic [COUNTER_W-1:0]  fifo_cnt_t;

    // Occupancy after one edge, given which of push/pop actually took effect.
    function automatic fifo_cnt_t count_after(input fifo_cnt_t cnt,
                                              input logic      inc,
                                              input logic      dec);
        fifo_cnt_t result;
        result = cnt;
        if (inc && !dec) begin
            result = cnt + fifo_cnt_t'(1);
        end else if (dec && !inc) begin
            result = cnt - fifo_cnt_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tfifo_if.sv
// Push/pop/status bundle between the register file + transmitter (master)
// and the transmit FIFO (slave).
//   master drives: data_in, push, pop, fifo_reset, reset_status
//   slave drives : data_out, count, full, empty, almost_empty,
//                  overflow, underrun
interface uart_tfifo_if;
    import uart_tfifo_pkg::*;

    fifo_data_t data_in;
    logic       push;
    logic       pop;
    logic       fifo_reset;
    logic       reset_status;
    fifo_data_t data_out;
    fifo_cnt_t  count;
    logic       full;
    logic       empty;
    logic       almost_empty;
    logic       overflow;
    logic       underrun;

    modport master (
        output data_in, push, pop, fifo_reset, reset_status,
        input  data_out, count, full, empty, almost_empty, overflow, underrun
    );

    modport slave (
        input  data_in, push, pop, fifo_reset, reset_status,
        output data_out, count, full, empty, almost_empty, overflow, underrun
    );

endinterface

// File: rtl/uart_tfifo_tf_raminfr.sv
// tf_raminfr: FIFO storage array.
// Synchronous write at address top when we is high; asynchronous read of
// address bottom so the FIFO head is visible without a cycle of latency.
// Contents are deliberately not reset.
//   clk      in  clock
//   we       in  write enable
//   top      in  write address
//   data_in  in  write data
//   bottom   in  read address
//   data_out out read data (combinational)
module tf_raminfr #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] top,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] bottom,
    output logic [WIDTH-1:0]  data_out
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[top] <= data_in;
        end
    end

    assign data_out = mem[bottom];

endmodule

// File: rtl/uart_tfifo.sv
// uart_tfifo: transmit-side byte FIFO of the UART.
// Buffers bytes written through the THR strobe (push) until the transmitter
// consumes them (pop). Reports occupancy, full/empty/almost-empty and sticky
// overflow/underrun flags.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  uart_tfifo_if.slave: push/pop side inputs, head data and status out
module uart_tfifo
    import uart_tfifo_pkg::*;
#(
    parameter int AE_LEVEL = UART_TFIFO_AE_LEVEL
) (
    input  logic        clk,
    input  logic        rst,
    uart_tfifo_if.slave bus
);

    fifo_ptr_t top_reg,    top_next;
    fifo_ptr_t bottom_reg, bottom_next;
    fifo_cnt_t count_reg,  count_next;
    logic      overflow_reg, overflow_next;
    logic      underrun_reg, underrun_next;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;
    logic we;

    assign full  = (count_reg == fifo_cnt_t'(FIFO_DEPTH));
    assign empty = (count_reg == '0);

    // A push at full still goes in when a pop frees the head slot in the
    // same cycle; a pop at empty is always dropped.
    assign push_ok = bus.push & (~full | bus.pop);
    assign pop_ok  = bus.pop & ~empty;
    assign we      = push_ok & ~bus.fifo_reset;

    always_comb begin
        top_next      = top_reg + fifo_ptr_t'(push_ok);
        bottom_next   = bottom_reg + fifo_ptr_t'(pop_ok);
        count_next    = count_after(count_reg, push_ok, pop_ok);
        overflow_next = overflow_reg | (bus.push & full & ~bus.pop);
        underrun_next = underrun_reg | (bus.pop & empty);
        // Status clear beats a set event in the same cycle.
        if (bus.reset_status) begin
            overflow_next = 1'b0;
            underrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_reg      <= '0;
            bottom_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else if (bus.fifo_reset) begin
            top_reg      <= '0;
            bottom_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            top_reg      <= top_next;
            bottom_reg   <= bottom_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            underrun_reg <= underrun_next;
        end
    end

    tf_raminfr #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (POINTER_W)
    ) u_ram (
        .clk      (clk),
        .we       (we),
        .top      (top_reg),
        .data_in  (bus.data_in),
        .bottom   (bottom_reg),
        .data_out (bus.data_out)
    );

    assign bus.count        = count_reg;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_empty = (count_reg <= fifo_cnt_t'(AE_LEVEL));
    assign bus.overflow     = overflow_reg;
    assign bus.underrun     = underrun_reg;

endmodule

// File: tb/tb_uart_tfifo.sv
// Self-checking bench for uart_tfifo. The reference model is a byte queue
// plus two sticky flags; every pop expectation goes to a scoreboard queue
// that a separate monitor drains while the pop is on the bus.
module tb_uart_tfifo;

    localparam int DEPTH = 16;
    localparam int AE    = 2;

    typedef struct {
        bit         valid;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] model_q[$];
    bit         m_ovf;
    bit         m_unr;
    exp_t       sb_q[$];

    uart_tfifo_if bus ();

    uart_tfifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: while an effective-or-underrun pop is on the bus, compare the
    // head the transmitter would sample against the scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.pop && !bus.fifo_reset) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_entry", 0, 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.valid) begin
                    chk("pop_data", int'(bus.data_out), int'(e.data));
                    chk("pop_not_empty", int'(bus.empty), 0);
                    $display("pop  data=0x%02h expected=0x%02h", bus.data_out, e.data);
                end else begin
                    chk("pop_underrun_empty", int'(bus.empty), 1);
                    $display("pop  on empty fifo (underrun)");
                end
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, "_count"}, int'(bus.count), model_q.size());
        chk({tag, "_full"}, int'(bus.full), int'(model_q.size() == DEPTH));
        chk({tag, "_empty"}, int'(bus.empty), int'(model_q.size() == 0));
        chk({tag, "_almost_empty"}, int'(bus.almost_empty), int'(model_q.size() <= AE));
        chk({tag, "_overflow"}, int'(bus.overflow), int'(m_ovf));
        chk({tag, "_underrun"}, int'(bus.underrun), int'(m_unr));
        if (model_q.size() > 0) begin
            chk({tag, "_head"}, int'(bus.data_out), int'(model_q[0]));
        end
    endtask

    // One clock of stimulus: drive, post expectations, step, update model, check.
    task automatic cyc(input bit p, input bit q, input logic [7:0] d,
                       input bit fr = 1'b0, input bit rs = 1'b0);
        exp_t e;
        bit   popped;
        bit   set_ovf;
        bit   set_unr;
        bus.push         = p;
        bus.pop          = q;
        bus.data_in      = d;
        bus.fifo_reset   = fr;
        bus.reset_status = rs;
        if (q && !fr) begin
            e.valid = (model_q.size() > 0);
            e.data  = e.valid ? model_q[0] : 8'h00;
            sb_q.push_back(e);
        end
        if (p) $display("push data=0x%02h pop=%0b fr=%0b rs=%0b", d, q, fr, rs);
        @(posedge clk);
        #1;
        if (fr) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unr = 1'b0;
        end else begin
            popped  = q && (model_q.size() > 0);
            set_unr = q && (model_q.size() == 0);
            set_ovf = 1'b0;
            if (popped) void'(model_q.pop_front());
            if (p) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else set_ovf = 1'b1;
            end
            if (rs) begin
                m_ovf = 1'b0;
                m_unr = 1'b0;
            end else begin
                m_ovf = m_ovf | set_ovf;
                m_unr = m_unr | set_unr;
            end
        end
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.fifo_reset   = 1'b0;
        bus.reset_status = 1'b0;
        check_status("cyc");
    endtask

    task automatic async_reset_check();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_unr = 1'b0;
        $display("async reset asserted mid-cycle");
        check_status("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_status("after_rst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;
        m_unr  = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = 8'h00;
        bus.fifo_reset = 1'b0;
        bus.reset_status = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill to full, overflow with 0xAA, drain.
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
        cyc(1, 0, 8'hAA);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);
        cyc(0, 0, 8'h00, 0, 1);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'($urandom));
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'h00);
        for (int i = 0; i < 12; i++) cyc(1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'h00);

        // Simultaneous push/pop at full.
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h80 + i));
        cyc(1, 1, 8'h55);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);

        // Simultaneous at empty, status clear, clear racing an overflow.
        cyc(1, 1, 8'h77);
        cyc(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 15; i++) cyc(1, 0, 8'($urandom));
        cyc(1, 0, 8'hEE, 0, 1);
        for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00);

        // fifo_reset with a push pending at count 5.
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h10 + i));
        cyc(1, 0, 8'hDD, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h20 + i));
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h00);

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 1500; i++) begin
            int pp;
            pp = ((i / 150) % 2 == 0) ? 70 : 30;
            cyc($urandom_range(0, 99) < pp,
                $urandom_range(0, 99) < (100 - pp),
                8'($urandom),
                $urandom_range(0, 96) == 0,
                $urandom_range(0, 22) == 0);
            if (i == 700) async_reset_check();
        end

        for (int i = 0; i < 6; i++) cyc(1, 0, 8'($urandom));
        async_reset_check();
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
